// File: rtl/hcs_scan_controller.sv
// hcs_scan_controller: samples sensor operands, waits for the datapath to settle, captures and debounces its results
module hcs_scan_controller #(
    parameter int SCAN_PERIOD = 16,
    parameter int SETTLE      = 2,
    parameter int PERSIST     = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startScan,
    input  logic       autoScan,
    input  logic [5:0] pressureIn,
    input  logic [3:0] phIn,
    input  logic [2:0] bloodTypeIn,
    input  logic [7:0] fdSensorIn,
    input  logic [7:0] bloodSensorIn,
    input  logic [3:0] tempSensorIn,
    input  logic       cfgWe,
    input  logic [7:0] fdFactoryIn,
    input  logic [4:0] baseTempIn,
    input  logic [3:0] tempCoefIn,
    output logic [5:0] pressureData,
    output logic [3:0] bloodPH,
    output logic [2:0] bloodType,
    output logic [7:0] fdSensorValue,
    output logic [7:0] bloodSensor,
    output logic [3:0] tempSensorValue,
    output logic [7:0] fdFactoryValue,
    output logic [4:0] factotyBaseTemp,
    output logic [3:0] factotyTempCoef,
    input  logic [3:0] hcsFlags,
    input  logic [3:0] hcsGlycemic,
    output logic       resValid,
    input  logic       resReady,
    output logic [3:0] resFlags,
    output logic [3:0] resGlycemic,
    output logic [3:0] alarm,
    output logic       busy,
    output logic [7:0] scanCount
);
    localparam int PW = $clog2(SCAN_PERIOD);
    localparam int SW = SETTLE > 1 ? $clog2(SETTLE) : 1;
    localparam int CW = $clog2(PERSIST + 1);
    localparam logic [PW-1:0] PERIOD_TOP  = PW'(SCAN_PERIOD - 1);
    localparam logic [SW-1:0] SETTLE_TOP  = SW'(SETTLE - 1);
    localparam logic [CW-1:0] PERSIST_TOP = CW'(PERSIST);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLING, CAPTURE, HOLD} state_t;

    state_t        state, state_next;
    logic [PW-1:0] period_cnt;
    logic [SW-1:0] settle_cnt;
    logic [CW-1:0] persist_cnt [4];
    logic [CW-1:0] persist_next [4];
    logic          tick, load_en, capture_en, cfg_en;

    assign tick = autoScan && period_cnt == '0;

    // period counter keeps running during scans; ticks seen outside IDLE are simply lost
    always_ff @(posedge clk)
        if (rst || !autoScan || tick) period_cnt <= PERIOD_TOP;
        else period_cnt <= period_cnt - 1'b1;

    // state register
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_next;

    // next-state logic; a simultaneous start and tick yield one scan
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (startScan || tick) state_next = LOAD;
            LOAD:     state_next = SETTLING;
            SETTLING: if (settle_cnt == '0) state_next = CAPTURE;
            CAPTURE:  state_next = HOLD;
            HOLD:     if (resReady) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // state-decoded strobes
    always_comb begin
        busy       = state != IDLE;
        cfg_en     = state == IDLE && cfgWe;
        load_en    = state == LOAD;
        capture_en = state == CAPTURE;
    end

    // settle window countdown
    always_ff @(posedge clk)
        if (rst) settle_cnt <= '0;
        else if (load_en) settle_cnt <= SETTLE_TOP;
        else if (state == SETTLING && settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;

    // operand and factory registers feeding the datapath
    always_ff @(posedge clk)
        if (rst) begin
            pressureData    <= '0;
            bloodPH         <= '0;
            bloodType       <= '0;
            fdSensorValue   <= '0;
            bloodSensor     <= '0;
            tempSensorValue <= '0;
            fdFactoryValue  <= '0;
            factotyBaseTemp <= '0;
            factotyTempCoef <= '0;
        end else begin
            if (load_en) begin
                pressureData    <= pressureIn;
                bloodPH         <= phIn;
                bloodType       <= bloodTypeIn;
                fdSensorValue   <= fdSensorIn;
                bloodSensor     <= bloodSensorIn;
                tempSensorValue <= tempSensorIn;
            end
            if (cfg_en) begin
                fdFactoryValue  <= fdFactoryIn;
                factotyBaseTemp <= baseTempIn;
                factotyTempCoef <= tempCoefIn;
            end
        end

    // captured result and its valid/ready handshake
    always_ff @(posedge clk)
        if (rst) begin
            resValid    <= 1'b0;
            resFlags    <= '0;
            resGlycemic <= '0;
            scanCount   <= '0;
        end else if (capture_en) begin
            resValid    <= 1'b1;
            resFlags    <= hcsFlags;
            resGlycemic <= hcsGlycemic;
            scanCount   <= scanCount + 1'b1;
        end else if (state == HOLD && resReady) begin
            resValid    <= 1'b0;
        end

    // saturating consecutive-flag counters
    always_comb
        for (int i = 0; i < 4; i++)
            persist_next[i] = !hcsFlags[i] ? '0 :
                              persist_cnt[i] == PERSIST_TOP ? PERSIST_TOP : persist_cnt[i] + 1'b1;

    // alarms follow the counters on each capture
    always_ff @(posedge clk)
        for (int i = 0; i < 4; i++)
            if (rst) begin
                persist_cnt[i] <= '0;
                alarm[i]       <= 1'b0;
            end else if (capture_en) begin
                persist_cnt[i] <= persist_next[i];
                alarm[i]       <= persist_next[i] == PERSIST_TOP;
            end
endmodule

// File: tb/tb_hcs_scan_controller.sv
// tb_hcs_scan_controller: directed and random stimulus against a scan-timeline reference model
module tb_hcs_scan_controller;
    localparam int SP = 16, ST = 2, PE = 3;

    logic       clk = 0, rst, startScan, autoScan, cfgWe, resReady;
    logic [5:0] pressureIn;
    logic [3:0] phIn, tempSensorIn, tempCoefIn, hcsFlags, hcsGlycemic;
    logic [2:0] bloodTypeIn;
    logic [7:0] fdSensorIn, bloodSensorIn, fdFactoryIn;
    logic [4:0] baseTempIn;
    logic [5:0] pressureData;
    logic [3:0] bloodPH, tempSensorValue, factotyTempCoef, resFlags, resGlycemic, alarm;
    logic [2:0] bloodType;
    logic [7:0] fdSensorValue, bloodSensor, fdFactoryValue, scanCount;
    logic [4:0] factotyBaseTemp;
    logic       resValid, busy;

    hcs_scan_controller #(.SCAN_PERIOD(SP), .SETTLE(ST), .PERSIST(PE)) dut (
        .clk(clk), .rst(rst), .startScan(startScan), .autoScan(autoScan),
        .pressureIn(pressureIn), .phIn(phIn), .bloodTypeIn(bloodTypeIn), .fdSensorIn(fdSensorIn),
        .bloodSensorIn(bloodSensorIn), .tempSensorIn(tempSensorIn), .cfgWe(cfgWe),
        .fdFactoryIn(fdFactoryIn), .baseTempIn(baseTempIn), .tempCoefIn(tempCoefIn),
        .pressureData(pressureData), .bloodPH(bloodPH), .bloodType(bloodType),
        .fdSensorValue(fdSensorValue), .bloodSensor(bloodSensor), .tempSensorValue(tempSensorValue),
        .fdFactoryValue(fdFactoryValue), .factotyBaseTemp(factotyBaseTemp), .factotyTempCoef(factotyTempCoef),
        .hcsFlags(hcsFlags), .hcsGlycemic(hcsGlycemic), .resValid(resValid), .resReady(resReady),
        .resFlags(resFlags), .resGlycemic(resGlycemic), .alarm(alarm), .busy(busy), .scanCount(scanCount)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;

    // reference model: a scan is a timeline of edges counted from the start edge
    bit   m_active, m_valid;
    int   m_age, m_auto_run, m_cnt;
    int   m_run [4];
    logic [5:0] m_p;
    logic [3:0] m_ph, m_ts, m_tc, m_flags, m_gly;
    logic [2:0] m_bt;
    logic [7:0] m_fds, m_bs, m_fd;
    logic [4:0] m_base;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit tick;
        if (rst) begin
            m_active = 0; m_valid = 0; m_age = 0; m_auto_run = 0; m_cnt = 0;
            m_p = 0; m_ph = 0; m_ts = 0; m_tc = 0; m_flags = 0; m_gly = 0;
            m_bt = 0; m_fds = 0; m_bs = 0; m_fd = 0; m_base = 0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
        end else begin
            m_auto_run = autoScan ? m_auto_run + 1 : 0;
            tick = autoScan && (m_auto_run % SP == 0);
            if (!m_active) begin
                if (cfgWe) begin m_fd = fdFactoryIn; m_base = baseTempIn; m_tc = tempCoefIn; end
                if (startScan || tick) begin m_active = 1; m_age = 0; end
            end else if (m_valid) begin
                if (resReady) begin m_valid = 0; m_active = 0; end
            end else begin
                m_age++;
                if (m_age == 1) begin
                    m_p = pressureIn; m_ph = phIn; m_bt = bloodTypeIn;
                    m_fds = fdSensorIn; m_bs = bloodSensorIn; m_ts = tempSensorIn;
                end
                if (m_age == ST + 2) begin
                    m_flags = hcsFlags; m_gly = hcsGlycemic; m_valid = 1;
                    m_cnt = (m_cnt + 1) % 256;
                    for (int i = 0; i < 4; i++) m_run[i] = hcsFlags[i] ? m_run[i] + 1 : 0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [3:0] exp_alarm;
        for (int i = 0; i < 4; i++) exp_alarm[i] = m_run[i] >= PE;
        check("busy", busy, m_active);
        check("resValid", resValid, m_valid);
        check("resFlags", resFlags, m_flags);
        check("resGlycemic", resGlycemic, m_gly);
        check("alarm", alarm, exp_alarm);
        check("scanCount", scanCount, m_cnt);
        check("pressureData", pressureData, m_p);
        check("bloodPH", bloodPH, m_ph);
        check("bloodType", bloodType, m_bt);
        check("fdSensorValue", fdSensorValue, m_fds);
        check("bloodSensor", bloodSensor, m_bs);
        check("tempSensorValue", tempSensorValue, m_ts);
        check("fdFactoryValue", fdFactoryValue, m_fd);
        check("factotyBaseTemp", factotyBaseTemp, m_base);
        check("factotyTempCoef", factotyTempCoef, m_tc);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare();
    endtask

    task automatic rand_raw();
        pressureIn = 6'($urandom); phIn = 4'($urandom); bloodTypeIn = 3'($urandom);
        fdSensorIn = 8'($urandom); bloodSensorIn = 8'($urandom); tempSensorIn = 4'($urandom);
    endtask

    initial begin
        int saved;
        bit found;
        rst = 1; startScan = 0; autoScan = 0; cfgWe = 0; resReady = 0;
        fdFactoryIn = 0; baseTempIn = 0; tempCoefIn = 0; hcsFlags = 0; hcsGlycemic = 0;
        rand_raw();
        step(); step();
        rst = 0;

        cfgWe = 1; fdFactoryIn = 50; baseTempIn = 20; tempCoefIn = 3;
        step();
        check("cfg_fd", fdFactoryValue, 50);
        check("cfg_base", factotyBaseTemp, 20);
        check("cfg_coef", factotyTempCoef, 3);
        cfgWe = 0;

        phIn = 6; fdSensorIn = 27; bloodSensorIn = 8'hAA; hcsFlags = 4'b0010; hcsGlycemic = 9;
        startScan = 1;
        step();
        startScan = 0;
        step();
        check("op_ph", bloodPH, 6);
        check("op_fd", fdSensorValue, 27);
        check("op_bs", bloodSensor, 8'hAA);
        rand_raw();
        cfgWe = 1; fdFactoryIn = 99; baseTempIn = 1; tempCoefIn = 9;
        step(); step();
        cfgWe = 0;
        check("early_valid", resValid, 0);
        check("settle_ph", bloodPH, 6);
        check("busy_cfg", fdFactoryValue, 50);
        step();
        check("lat_valid", resValid, 1);
        check("lat_flags", resFlags, 4'b0010);
        check("lat_gly", resGlycemic, 9);
        check("lat_count", scanCount, 1);

        hcsFlags = 4'b0101; hcsGlycemic = 3;
        for (int i = 0; i < 10; i++) begin
            startScan = i[0];
            step();
            check("hold_valid", resValid, 1);
            check("hold_flags", resFlags, 4'b0010);
            check("hold_busy", busy, 1);
        end
        startScan = 0; resReady = 1;
        step();
        check("ack_valid", resValid, 0);
        check("ack_busy", busy, 0);

        autoScan = 1; hcsFlags = 4'b1000;
        repeat (3 * SP + ST + 3) step();
        check("alarm_set", alarm, 4'b1000);
        check("auto_count", scanCount, 4);
        hcsFlags = 4'b0000;
        repeat (SP + 2) step();
        check("alarm_clr", alarm, 4'b0000);

        found = 0;
        for (int i = 0; i < 2 * SP && !found; i++) begin
            if ((m_auto_run + 1) % SP == 0 && !m_active) found = 1;
            else step();
        end
        check("tick_found", found, 1);
        saved = m_cnt;
        startScan = 1;
        step();
        startScan = 0;
        repeat (ST + 4) step();
        check("start_tick", scanCount, (saved + 1) % 256);
        autoScan = 0;

        hcsFlags = 4'b1111;
        repeat (ST + 4) begin startScan = 1; step(); end
        startScan = 1; step(); startScan = 0; step(); step();
        rst = 1; step(); rst = 0;
        check("rst_settle_busy", busy, 0);
        check("rst_settle_valid", resValid, 0);
        check("rst_settle_alarm", alarm, 0);
        check("rst_settle_count", scanCount, 0);
        check("rst_settle_fd", fdFactoryValue, 0);

        resReady = 0; startScan = 1;
        repeat (ST + 5) step();
        startScan = 0;
        check("pre_rst_valid", resValid, 1);
        rst = 1; step(); rst = 0;
        check("rst_hold_busy", busy, 0);
        check("rst_hold_valid", resValid, 0);
        check("rst_hold_count", scanCount, 0);

        resReady = 1; startScan = 1;
        for (int i = 0; i < 256 * (ST + 4); i++) begin
            hcsFlags = 4'($urandom); hcsGlycemic = 4'($urandom);
            step();
        end
        startScan = 0;
        check("wrap_count", scanCount, 0);

        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 299) == 0;
            startScan = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 99) == 0) autoScan = ~autoScan;
            cfgWe = $urandom_range(0, 3) == 0;
            resReady = $urandom_range(0, 1);
            fdFactoryIn = 8'($urandom); baseTempIn = 5'($urandom); tempCoefIn = 4'($urandom);
            hcsFlags = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'b1010;
            hcsGlycemic = 4'($urandom);
            rand_raw();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/hcs_scan_controller.md
Name: hcs_scan_controller

Overview:
- Sequencer in front of the combinational healthCareSystem datapath.
- Samples the raw sensor bus, on demand or periodically, into stable operand registers, and holds the factory calibration registers.
- Waits a settle window, then captures the four abnormality flags and glycemicIndex.
- Debounces the flags into persistent alarms and hands each result to a consumer over a valid/ready handshake.

Parameters:
- SCAN_PERIOD, 16: cycles between auto-scan ticks; minimum 2.
- SETTLE, 2: cycles operands are held before capture; minimum 1.
- PERSIST, 3: consecutive flagged scans needed to raise an alarm; minimum 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- startScan  in  1  one-shot scan request; honoured only in IDLE.
- autoScan  in  1  enables periodic scanning.
- pressureIn  in  6  raw pressure sample.
- phIn  in  4  raw blood pH.
- bloodTypeIn  in  3  raw blood type.
- fdSensorIn  in  8  raw fall-detector sample.
- bloodSensorIn  in  8  raw blood sensor.
- tempSensorIn  in  4  raw temperature sample.
- cfgWe  in  1  factory config write strobe.
- fdFactoryIn  in  8  fall-detector factory value.
- baseTempIn  in  5  factory base temperature.
- tempCoefIn  in  4  factory temperature coefficient.
- pressureData, bloodPH, bloodType, fdSensorValue, bloodSensor, tempSensorValue  out  6/4/3/8/8/4  registered operands to healthCareSystem.
- fdFactoryValue, factotyBaseTemp, factotyTempCoef  out  8/5/4  factory registers to healthCareSystem.
- hcsFlags  in  4  {presureAbnormality, bloodAbnormality, fallDetected, temperatureAbnormality}.
- hcsGlycemic  in  4  glycemicIndex from healthCareSystem.
- resValid  out  1  captured result available.
- resReady  in  1  consumer accepts the result.
- resFlags  out  4  captured flags.
- resGlycemic  out  4  captured glycemicIndex.
- alarm  out  4  debounced flags, same bit order as hcsFlags.
- busy  out  1  high in any state other than IDLE.
- scanCount  out  8  completed scans, wraps 255->0.

Behaviour:
- Reset: every register and output is 0, including the factory registers. State goes to IDLE and the period counter to SCAN_PERIOD-1. Reset mid-scan aborts the scan, drops any pending result and clears the alarms.
- Period counter: while autoScan=1, decrements every cycle; on reaching 0 it produces a tick and reloads SCAN_PERIOD-1. While autoScan=0, held at SCAN_PERIOD-1. A tick that occurs outside IDLE is dropped; the counter is not paused.
- FSM IDLE: goes to LOAD if startScan or a tick is present. Start and tick in the same cycle produce a single scan. cfgWe writes the factory registers only in IDLE; outside IDLE it is ignored.
- FSM LOAD, 1 cycle: all six operand registers load from the raw inputs; settle counter set to SETTLE-1; next state SETTLE.
- FSM SETTLE: counter decrements each cycle; when it is 0, next state CAPTURE. Operands are stable for the whole window.
- FSM CAPTURE, 1 cycle:
  - resFlags <= hcsFlags and resGlycemic <= hcsGlycemic.
  - Persistence counters update.
  - scanCount increments.
  - resValid is set; next state HOLD.
- FSM HOLD: resValid stays high and resFlags/resGlycemic stay stable. When resReady=1, resValid clears on that edge and the next state is IDLE. A new scan can start at the earliest one cycle after IDLE is re-entered.
- Latency: resValid goes high SETTLE+2 edges after the edge that samples startScan in IDLE.
- Persistence, per bit i:
  - Saturating counter of width clog2(PERSIST+1).
  - Captured flag 1: counter increments, saturating at PERSIST.
  - Captured flag 0: counter clears to 0.
  - alarm[i] is registered and equals (counter == PERSIST), updated on the CAPTURE edge.
  - With PERSIST=1, alarm mirrors resFlags.
- startScan arriving outside IDLE is ignored; it is not queued.

Test Plan:
1. Reset, then cfgWe=1 with fdFactoryIn=50, baseTempIn=20, tempCoefIn=3 -> next cycle fdFactoryValue=50, factotyBaseTemp=20, factotyTempCoef=3. A cfgWe during busy=1 leaves them unchanged.
2. startScan pulse with phIn=6, fdSensorIn=27, bloodSensorIn=8'hAA, stub hcsFlags=4'b0010, hcsGlycemic=9 -> operands update one edge later; resValid high 4 edges after the start edge; resFlags=0010, resGlycemic=9, scanCount=1. Raw inputs changed during SETTLE must not alter the operands.
3. Hold resReady=0 for 10 cycles -> resValid, resFlags and busy stay high. A startScan during the hold is ignored. resReady=1 -> resValid=0 next edge, state IDLE.
4. autoScan=1, resReady tied 1, hcsFlags=4'b1000 for 3 scans -> alarm=1000 after the 3rd capture. Scans start 16 cycles apart. One scan with flags 0 -> alarm=0000.
5. autoScan=1 and startScan on the same cycle as a tick -> scanCount increases by exactly 1.
6. rst during SETTLE, and separately during HOLD -> next cycle busy=0, resValid=0, alarm=0, scanCount=0, factory registers 0. 256 completed scans -> scanCount wraps to 0.
